// File: rtl/pipeline_scoreboard.sv
// pipeline_scoreboard: per-register countdown scoreboard for variable-latency
// execute units. It raises stall for RAW/WAW hazards that the bypass network
// cannot cover, and produces per-source forwarding selects.
// Optional feature macro: SCOREBOARD_STATS_EN (adds the stall_cycles counter).
module pipeline_scoreboard #(
  parameter int NREGS    = 32,
  parameter int ADDR_W   = 5,
  parameter int LAT_W    = 3,
  parameter int BYPASS   = 2,
  parameter int ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic              dst_wr,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LAT_W-1:0]  issue_lat,
  input  logic [2:0]        src_en,
  input  logic [ADDR_W-1:0] src0,
  input  logic [ADDR_W-1:0] src1,
  input  logic [ADDR_W-1:0] src2,
  input  logic              flush,
  output logic              stall,
  output logic [LAT_W-1:0]  fwd_sel0,
  output logic [LAT_W-1:0]  fwd_sel1,
  output logic [LAT_W-1:0]  fwd_sel2,
  output logic [NREGS-1:0]  busy
`ifdef SCOREBOARD_STATS_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  localparam logic [LAT_W-1:0]  BYPASS_CNT = LAT_W'(BYPASS);
  localparam logic [ADDR_W-1:0] ZERO_IDX   = ADDR_W'(ZERO_REG);

  // Remaining cycles until each register's pending write lands; 0 = in regfile.
  logic [LAT_W-1:0]  cnt [NREGS];

  logic [ADDR_W-1:0] srcIdx [3];
  logic [LAT_W-1:0]  srcCnt [3];
  logic [2:0]        srcLive;
  logic [2:0]        srcHaz;
  logic [LAT_W-1:0]  fwdSel [3];
  logic              wawHaz;
  logic              issueAcc;

  assign srcIdx[0] = src0;
  assign srcIdx[1] = src1;
  assign srcIdx[2] = src2;

  // Look up each enabled source's counter and flag what bypass cannot cover.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    for (int i = 0; i < 3; i++) begin
      srcCnt[i]  = '0;
      srcLive[i] = 1'b0;
      srcHaz[i]  = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      srcCnt[i]  = cnt[srcIdx[i]];
      srcLive[i] = src_en[i] && (srcIdx[i] != ZERO_IDX);
      srcHaz[i]  = srcLive[i] && (srcCnt[i] > BYPASS_CNT);
    end
  end

  // A younger write must never complete before an older one to the same reg.
  assign wawHaz = dst_wr && (dst != ZERO_IDX) && (issue_lat < cnt[dst]);

  // Flush squashes the instruction, so it never holds decode.
  assign stall = issue_valid && !flush && ((|srcHaz) || wawHaz);

  // A zero latency write is not tracked at all.
  assign issueAcc = issue_valid && !stall && !flush && dst_wr &&
                    (dst != ZERO_IDX) && (issue_lat != '0);

  // Forward from the stage the counter names; register file while stalled.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      fwdSel[i] = '0;
      if (srcLive[i] && !srcHaz[i] && !stall) fwdSel[i] = srcCnt[i];
    end
  end

  assign fwd_sel0 = fwdSel[0];
  assign fwd_sel1 = fwdSel[1];
  assign fwd_sel2 = fwdSel[2];

  // Pending bit per register; the zero register never reports busy.
  always_comb begin
    busy = '0;
    for (int r = 0; r < NREGS; r++) begin
      busy[r] = (cnt[r] != '0) && (r != ZERO_REG);
    end
  end

  // Countdown: flush clears all, an accepted issue reloads its destination.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the counters form a small state array, not a RAM; every entry
      // must be cleared on reset or stale pending writes would stall forever.
      for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        // NOTE: non-blocking assignments keep every counter reading the
        // pre-edge values regardless of loop order.
        if (flush)                                cnt[r] <= '0;
        else if (issueAcc && (dst == ADDR_W'(r))) cnt[r] <= issue_lat;
        else if (cnt[r] != '0)                    cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

`ifdef SCOREBOARD_STATS_EN
  // Saturating count of cycles spent stalled; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                     stall_cycles <= '0;
    else if (stall && (stall_cycles != 32'hFFFF_FFFF)) stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Self-checking bench for pipeline_scoreboard: directed vector table for the
// hazard/forwarding corners, then random traffic against a remaining-cycles
// model, then an asynchronous reset in the middle of a stall.
module tb_pipeline_scoreboard;

  localparam int NREGS = 32;
  localparam int ZREG  = 31;
  localparam int BYP   = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       issue_valid, dst_wr, flush;
  logic [4:0] dst, src0, src1, src2;
  logic [2:0] issue_lat, src_en;
  logic       stall;
  logic [2:0] fwd_sel0, fwd_sel1, fwd_sel2;
  logic [31:0] busy;
`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles;
`endif

  pipeline_scoreboard dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .dst_wr(dst_wr),
    .dst(dst), .issue_lat(issue_lat), .src_en(src_en), .src0(src0),
    .src1(src1), .src2(src2), .flush(flush), .stall(stall),
    .fwd_sel0(fwd_sel0), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .busy(busy)
`ifdef SCOREBOARD_STATS_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid, wr;
    logic [4:0] dst;
    logic [2:0] lat, en;
    logic [4:0] s0, s1;
    logic       fl;
    logic       eStall;
    logic [2:0] eF0, eF1;
    logic [31:0] eBusy;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;
  int   rem [NREGS];     // model: cycles until each register's value lands
  int   stallCnt = 0;    // model: cycles with stall expected

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic w, input int d, input int l,
                              input int en, input int a, input int b, input logic f,
                              input logic st, input int f0, input int f1, input logic [31:0] bz);
    vec_t t;
    t.valid = v; t.wr = w; t.dst = 5'(d); t.lat = 3'(l); t.en = 3'(en);
    t.s0 = 5'(a); t.s1 = 5'(b); t.fl = f;
    t.eStall = st; t.eF0 = 3'(f0); t.eF1 = 3'(f1); t.eBusy = bz;
    return t;
  endfunction

  function automatic logic [31:0] bit_of(input int r);
    logic [31:0] one;
    one = 32'd1;
    return one << r;
  endfunction

  // Expected outputs from the rules: hazard if a live source still has more
  // cycles to go than bypass reaches, or the new write would land too early.
  task automatic model_expect(output logic st, output logic [2:0] f0, output logic [2:0] f1,
                              output logic [2:0] f2, output logic [31:0] bz);
    int   s [3];
    int   f [3];
    logic haz;
    s[0] = int'(src0); s[1] = int'(src1); s[2] = int'(src2);
    haz = 1'b0;
    for (int i = 0; i < 3; i++) begin
      f[i] = 0;
      if (src_en[i] && s[i] != ZREG) begin
        if (rem[s[i]] > BYP) haz = 1'b1;
        else                 f[i] = rem[s[i]];
      end
    end
    if (dst_wr && int'(dst) != ZREG && int'(issue_lat) < rem[dst]) haz = 1'b1;
    st = issue_valid && !flush && haz;
    if (st) begin f[0] = 0; f[1] = 0; f[2] = 0; end
    f0 = 3'(f[0]); f1 = 3'(f[1]); f2 = 3'(f[2]);
    bz = '0;
    for (int r = 0; r < NREGS; r++) if (rem[r] > 0) bz[r] = 1'b1;
  endtask

  // Clock edge, then move the model one cycle forward using the held inputs.
  task automatic advance(input logic st);
    @(posedge clk);
    if (st) stallCnt++;
    if (flush) begin
      for (int r = 0; r < NREGS; r++) rem[r] = 0;
    end else begin
      for (int r = 0; r < NREGS; r++) if (rem[r] > 0) rem[r]--;
      if (issue_valid && !st && dst_wr && int'(dst) != ZREG && issue_lat != 0)
        rem[dst] = int'(issue_lat);
    end
    #1;
  endtask

  task automatic drive(input vec_t t, input logic [4:0] s2, input logic en2);
    issue_valid = t.valid; dst_wr = t.wr; dst = t.dst; issue_lat = t.lat;
    src_en = {en2, t.en[1:0]}; src0 = t.s0; src1 = t.s1; src2 = s2; flush = t.fl;
  endtask

  function automatic logic [4:0] pick_reg();
    if ($urandom_range(0, 9) == 0) return 5'(ZREG);
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    logic        st;
    logic [2:0]  f0, f1, f2;
    logic [31:0] bz;
    vec_t        t;

    for (int r = 0; r < NREGS; r++) rem[r] = 0;
    reset = 1'b0;
    t = mk(0,0,0,0,0,0,0,0, 0,0,0,0);
    drive(t, 5'd0, 1'b0);
    #3;
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_busy", busy, 32'd0);
    check("reset_fwd0", 32'(fwd_sel0), 32'd0);
    #4 reset = 1'b1;
    @(posedge clk); #1;

    // v, wr, dst, lat, en, s0, s1, flush | stall, fwd0, fwd1, busy
    vecs.push_back(mk(1,1,3,4,0,0,0,0, 0,0,0,0));           // X3 lat 4
    for (int k = 0; k < 4; k++) vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,bit_of(3)));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0));           // X3 done
    vecs.push_back(mk(1,1,5,4,0,0,0,0, 0,0,0,0));           // load X5 lat 4
    vecs.push_back(mk(1,0,0,0,1,5,0,0, 1,0,0,bit_of(5)));   // cnt 4
    vecs.push_back(mk(1,0,0,0,1,5,0,0, 1,0,0,bit_of(5)));   // cnt 3
    vecs.push_back(mk(1,0,0,0,1,5,0,0, 0,2,0,bit_of(5)));   // cnt 2 bypass
    vecs.push_back(mk(1,0,0,0,1,5,0,0, 0,1,0,bit_of(5)));
    vecs.push_back(mk(1,0,0,0,1,5,0,0, 0,0,0,0));
    vecs.push_back(mk(1,1,7,5,0,0,0,0, 0,0,0,0));           // X7 lat 5
    vecs.push_back(mk(1,1,7,2,0,0,0,0, 1,0,0,bit_of(7)));   // WAW cnt 5
    vecs.push_back(mk(1,1,7,2,0,0,0,0, 1,0,0,bit_of(7)));   // cnt 4
    vecs.push_back(mk(1,1,7,2,0,0,0,0, 1,0,0,bit_of(7)));   // cnt 3
    vecs.push_back(mk(1,1,7,2,0,0,0,0, 0,0,0,bit_of(7)));   // cnt 2 accepted
    vecs.push_back(mk(0,0,0,0,2,0,7,0, 0,0,2,bit_of(7)));   // reloaded to 2
    vecs.push_back(mk(0,0,0,0,2,0,7,0, 0,0,1,bit_of(7)));
    vecs.push_back(mk(1,1,31,7,0,0,0,0, 0,0,0,0));          // zero reg write
    vecs.push_back(mk(1,0,0,0,2,0,31,0, 0,0,0,0));          // zero reg source
    vecs.push_back(mk(1,1,2,3,0,0,0,0, 0,0,0,0));
    vecs.push_back(mk(1,1,1,6,0,0,0,0, 0,0,0,bit_of(2)));
    vecs.push_back(mk(1,1,4,5,1,1,0,1, 0,0,0,bit_of(1)|bit_of(2))); // flush
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,4,0,0, 0,0,0,0));           // X4 dropped
    vecs.push_back(mk(1,1,6,3,0,0,0,0, 0,0,0,0));
    vecs.push_back(mk(1,1,6,5,1,6,0,0, 1,0,0,bit_of(6)));   // src==dst, cnt 3
    vecs.push_back(mk(1,1,6,5,1,6,0,0, 0,2,0,bit_of(6)));   // pre-issue cnt 2
    vecs.push_back(mk(1,0,0,0,1,6,0,0, 1,0,0,bit_of(6)));   // reloaded to 5
    vecs.push_back(mk(0,0,0,0,0,0,0,1, 0,0,0,bit_of(6)));   // flush
    vecs.push_back(mk(1,1,8,0,0,0,0,0, 0,0,0,0));           // lat 0
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0));           // X8 untracked

    foreach (vecs[i]) begin
      drive(vecs[i], 5'd0, 1'b0);
      #2;
      check($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].eStall));
      check($sformatf("vec%0d_fwd0", i), 32'(fwd_sel0), 32'(vecs[i].eF0));
      check($sformatf("vec%0d_fwd1", i), 32'(fwd_sel1), 32'(vecs[i].eF1));
      check($sformatf("vec%0d_fwd2", i), 32'(fwd_sel2), 32'd0);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].eBusy);
      model_expect(st, f0, f1, f2, bz);
      advance(st);
    end

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      t = mk($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, int'(pick_reg()),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), int'(pick_reg()),
             int'(pick_reg()), $urandom_range(0, 24) == 0, 0,0,0,0);
      drive(t, pick_reg(), 1'($urandom_range(0, 1)));
      #2;
      model_expect(st, f0, f1, f2, bz);
      check($sformatf("rnd%0d_stall", n), 32'(stall), 32'(st));
      check($sformatf("rnd%0d_fwd0", n), 32'(fwd_sel0), 32'(f0));
      check($sformatf("rnd%0d_fwd1", n), 32'(fwd_sel1), 32'(f1));
      check($sformatf("rnd%0d_fwd2", n), 32'(fwd_sel2), 32'(f2));
      check($sformatf("rnd%0d_busy", n), busy, bz);
      advance(st);
    end
`ifdef SCOREBOARD_STATS_EN
    check("stall_cycles_count", stall_cycles, 32'(stallCnt));
`endif

    // Asynchronous reset in the middle of a stall.
    drive(mk(1,1,9,7,0,0,0,0, 0,0,0,0), 5'd0, 1'b0);
    #2;
    model_expect(st, f0, f1, f2, bz);
    advance(st);
    drive(mk(1,0,0,0,1,9,0,0, 0,0,0,0), 5'd0, 1'b0);
    #2;
    check("pre_reset_stall", 32'(stall), 32'd1);
    check("pre_reset_busy9", 32'(busy[9]), 32'd1);
    reset = 1'b0;
    #1;
    check("async_reset_stall", 32'(stall), 32'd0);
    check("async_reset_busy", busy, 32'd0);
`ifdef SCOREBOARD_STATS_EN
    check("async_reset_stats", stall_cycles, 32'd0);
`endif
    for (int r = 0; r < NREGS; r++) rem[r] = 0;
    stallCnt = 0;
    #2 reset = 1'b1;
    @(posedge clk); #1;
    drive(mk(0,0,0,0,1,9,0,0, 0,0,0,0), 5'd0, 1'b0);
    #2;
    check("post_reset_busy", busy, 32'd0);
    check("post_reset_fwd0", 32'(fwd_sel0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
